packet_add_arbiter: RTL and testbench

Round-robin AXI-stream job arbiter that shares one `packet_add_top` datapath among N requesters. Each requester presents a stream and its own `{k,len}` configuration. The block grants one requester for a whole job of k packets, forwards its beats unchanged, and drives the datapath's `config_packet` stably for the job's duration. It sits directly upstream of `packet_add_top`; `m_*` and `config_packet` connect to that block's `s_*` and `config_packet` ports.

---
 rtl/packet_add_pkg.sv | 21 ++
 rtl/rr_picker.sv | 34 +++
 rtl/packet_add_arbiter.sv | 157 +++++++++++++++
 tb/tb_packet_add_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_add_pkg.sv
// Shared types for the packet_add datapath and its upstream job arbiter.
package packet_add_pkg;

  localparam int PKT_DW = 8;

  typedef struct packed {
    logic [PKT_DW-1:0] k;
    logic [PKT_DW-1:0] len;
  } cfg_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Advance a requester index by one, wrapping back to zero after n-1.
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N.
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Walk every position once starting from ptr and keep the first hit.
  always_comb begin
    int cand;
    logic [IW-1:0] candIdx;
    cand    = 0;
    candIdx = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      candIdx = IW'(cand);
      if (!any && req[candIdx]) begin
        any     = 1'b1;
        gnt_idx = candIdx;
      end
    end
  end

endmodule

// File: rtl/packet_add_arbiter.sv
// Round-robin job arbiter in front of packet_add_top: grants one requester
// for a whole job of k packets and holds its {k,len} config steady meanwhile.
module packet_add_arbiter
  import packet_add_pkg::*;
#(
  parameter  int DW = PKT_DW,
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*DW-1:0]   s_tdata,
  input  logic [N-1:0]      s_tvalid,
  input  logic [N-1:0]      s_tlast,
  output logic [N-1:0]      s_tready,
  input  logic [N*2*DW-1:0] cfg_in,
  output logic [DW-1:0]     m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [2*DW-1:0]   config_packet,
  output logic [IW-1:0]     m_tid,
  output logic              busy,
  output logic              len_err
);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   tid_q, tid_d;
  logic [2*DW-1:0] cfg_q, cfg_d;
  logic [DW-1:0]   pktRem_q, pktRem_d;
  logic [DW-1:0]   beat_q, beat_d;
  logic            lenErr_q, lenErr_d;

  logic [IW-1:0]   pickIdx;
  logic            pickAny;
  logic [2*DW-1:0] pickCfg;
  logic [DW-1:0]   pickK;
  logic [DW-1:0]   curLen;
  logic [DW:0]     beatPlusOne;
  logic            beatFire;

  rr_picker #(
    .N(N)
  ) uPicker (
    .req    (s_tvalid),
    .ptr    (ptr_q),
    .gnt_idx(pickIdx),
    .any    (pickAny)
  );

  // Select the config of the requester the picker would grant this cycle.
  always_comb begin
    pickCfg = '0;
    for (int i = 0; i < N; i++) begin
      if (pickIdx == IW'(i)) begin
        pickCfg = cfg_in[i*2*DW +: 2*DW];
      end
    end
  end

  assign pickK       = pickCfg[2*DW-1:DW];
  assign curLen      = cfg_q[DW-1:0];
  assign beatPlusOne = {1'b0, beat_q} + {{DW{1'b0}}, 1'b1};
  assign beatFire    = m_tvalid & m_tready;

  // Pass the granted stream through; everything stays quiet outside a job.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == XFER) begin
      for (int i = 0; i < N; i++) begin
        if (tid_q == IW'(i)) begin
          m_tdata     = s_tdata[i*DW +: DW];
          m_tvalid    = s_tvalid[i];
          m_tlast     = s_tlast[i];
          s_tready[i] = m_tready;
        end
      end
    end
  end

  // Next-state logic: grant in IDLE, count beats and packets in XFER.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    tid_d    = tid_q;
    cfg_d    = cfg_q;
    pktRem_d = pktRem_q;
    beat_d   = beat_q;
    lenErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickAny) begin
          state_d  = XFER;
          tid_d    = pickIdx;
          cfg_d    = pickCfg;
          pktRem_d = (pickK == '0) ? DW'(1) : pickK;
          beat_d   = '0;
          ptr_d    = IW'(wrapInc(int'(pickIdx), N));
        end
      end
      XFER: begin
        if (beatFire) begin
          if (curLen != '0) begin
            if (m_tlast) begin
              lenErr_d = (beatPlusOne != {1'b0, curLen});
            end else begin
              lenErr_d = (beatPlusOne == {1'b0, curLen});
            end
          end
          if (m_tlast) begin
            beat_d   = '0;
            pktRem_d = pktRem_q - DW'(1);
            if (pktRem_q == DW'(1)) begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beatPlusOne[DW-1:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and job registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      tid_q    <= '0;
      cfg_q    <= '0;
      pktRem_q <= '0;
      beat_q   <= '0;
      lenErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      tid_q    <= tid_d;
      cfg_q    <= cfg_d;
      pktRem_q <= pktRem_d;
      beat_q   <= beat_d;
      lenErr_q <= lenErr_d;
    end
  end

  assign config_packet = cfg_q;
  assign m_tid         = tid_q;
  assign busy          = (state_q == XFER);
  assign len_err       = lenErr_q;

endmodule

// File: tb/tb_packet_add_arbiter.sv
// Bench for packet_add_arbiter: random requester traffic against a
// job-level reference model.
module tb_packet_add_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   s_tdata;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic [N*2*DW-1:0] cfg_in;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [2*DW-1:0]   config_packet;
  logic [IW-1:0]     m_tid;
  logic              busy;
  logic              len_err;

  int vectorCount = 0;
  int missCount   = 0;

  // Requester-side stream state
  logic [DW-1:0] headData[N];
  int            pktBeatsLeft[N];
  int            validPct;
  int            readyPct;
  int            lenMin;
  int            lenMax;
  bit            randCfg;

  // Reference job state
  bit              expBusy;
  int              expTid;
  int              expPtr;
  int              expPktLeft;
  int              expBeatCnt;
  logic [2*DW-1:0] expCfg;
  bit              expErr;

  packet_add_arbiter #(
    .DW(DW),
    .N (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .cfg_in       (cfg_in),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .config_packet(config_packet),
    .m_tid        (m_tid),
    .busy         (busy),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, wanted 0x%0h", tag, $time,
               observed, expected);
    end
  endtask

  task automatic modelReset();
    expBusy    = 1'b0;
    expTid     = 0;
    expPtr     = 0;
    expPktLeft = 0;
    expBeatCnt = 0;
    expCfg     = '0;
    expErr     = 1'b0;
  endtask

  task automatic initDrivers(input int minLen, input int maxLen);
    lenMin = minLen;
    lenMax = maxLen;
    for (int r = 0; r < N; r++) begin
      headData[r]     = DW'($urandom);
      pktBeatsLeft[r] = $urandom_range(lenMax, lenMin);
    end
  endtask

  task automatic advanceDriver(input int r);
    headData[r] = DW'($urandom);
    pktBeatsLeft[r]--;
    if (pktBeatsLeft[r] <= 0) begin
      pktBeatsLeft[r] = $urandom_range(lenMax, lenMin);
    end
  endtask

  task automatic applyStimulus();
    for (int r = 0; r < N; r++) begin
      s_tvalid[r]          = ($urandom_range(99) < validPct);
      s_tdata[r*DW +: DW]  = headData[r];
      s_tlast[r]           = (pktBeatsLeft[r] == 1);
      if (randCfg) begin
        cfg_in[r*2*DW +: 2*DW] = {DW'($urandom_range(3, 0)), DW'($urandom_range(7, 0))};
      end
    end
    m_tready = ($urandom_range(99) < readyPct);
  endtask

  task automatic checkAll();
    logic [DW-1:0] eData;
    logic          eValid;
    logic          eLast;
    logic [N-1:0]  eReady;
    eData  = '0;
    eValid = 1'b0;
    eLast  = 1'b0;
    eReady = '0;
    if (expBusy) begin
      eData          = s_tdata[expTid*DW +: DW];
      eValid         = s_tvalid[expTid];
      eLast          = s_tlast[expTid];
      eReady[expTid] = m_tready;
    end
    checkOutput("m_tvalid", 32'(m_tvalid), 32'(eValid));
    checkOutput("m_tdata", 32'(m_tdata), 32'(eData));
    checkOutput("m_tlast", 32'(m_tlast), 32'(eLast));
    checkOutput("s_tready", 32'(s_tready), 32'(eReady));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("m_tid", 32'(m_tid), 32'(expTid));
    checkOutput("config_packet", 32'(config_packet), 32'(expCfg));
    checkOutput("len_err", 32'(len_err), 32'(expErr));
  endtask

  // Advance the reference by one rising edge using the inputs just driven.
  task automatic modelEdge();
    bit found;
    bit isLast;
    int c;
    int lenV;
    int kV;
    found  = 1'b0;
    expErr = 1'b0;
    if (!expBusy) begin
      for (int i = 0; i < N; i++) begin
        c = (expPtr + i) % N;
        if (!found && s_tvalid[c]) begin
          found      = 1'b1;
          expBusy    = 1'b1;
          expTid     = c;
          expCfg     = cfg_in[c*2*DW +: 2*DW];
          kV         = int'(expCfg[2*DW-1:DW]);
          expPktLeft = (kV == 0) ? 1 : kV;
          expBeatCnt = 0;
          expPtr     = (c + 1) % N;
        end
      end
    end else if (s_tvalid[expTid] && m_tready) begin
      isLast = s_tlast[expTid];
      lenV   = int'(expCfg[DW-1:0]);
      if (lenV != 0) begin
        expErr = isLast ? (expBeatCnt + 1 != lenV) : (expBeatCnt + 1 == lenV);
      end
      advanceDriver(expTid);
      if (isLast) begin
        expBeatCnt = 0;
        if (expPktLeft == 1) begin
          expBusy = 1'b0;
        end
        expPktLeft--;
      end else begin
        expBeatCnt++;
      end
    end
  endtask

  // Drop reset between edges while a job is running, then release after an edge.
  task automatic applyReset();
    @(negedge clk);
    applyStimulus();
    #1;
    checkAll();
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic runCycles(input int n, input bit resetMidJob);
    bit pending;
    pending = resetMidJob;
    for (int cyc = 0; cyc < n; cyc++) begin
      if (pending && cyc > n / 2 && expBusy && expBeatCnt >= 2) begin
        pending = 1'b0;
        applyReset();
      end else begin
        @(negedge clk);
        applyStimulus();
        #1;
        checkAll();
        @(posedge clk);
        modelEdge();
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    cfg_in   = '0;
    m_tready = 1'b0;
    validPct = 0;
    readyPct = 0;
    randCfg  = 1'b0;
    modelReset();
    initDrivers(4, 4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAll();
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] all requesters valid, k=1 len=4");
    for (int r = 0; r < N; r++) begin
      cfg_in[r*2*DW +: 2*DW] = {DW'(1), DW'(4)};
    end
    validPct = 100;
    readyPct = 100;
    runCycles(60, 1'b0);

    $display("[TB] random traffic with backpressure and config churn");
    initDrivers(1, 8);
    randCfg  = 1'b1;
    validPct = 70;
    readyPct = 70;
    runCycles(2500, 1'b1);

    $display("[TB] random traffic, full throughput");
    validPct = 100;
    readyPct = 100;
    runCycles(600, 1'b1);

    $display("[TB] sparse traffic");
    validPct = 30;
    readyPct = 50;
    runCycles(600, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
